// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU instruction sequencer: opcode encodings,
// flag bit positions and the sequencer state type.
package alu_sequencer_pkg;

  localparam int unsigned NREG    = 4;
  localparam int unsigned ALU_OPS = 9;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0100;
  localparam logic [3:0] OP_NOT = 4'b0101;
  localparam logic [3:0] OP_CMP = 4'b0110;
  localparam logic [3:0] OP_SHL = 4'b0111;
  localparam logic [3:0] OP_SHR = 4'b1000;
  localparam logic [3:0] OP_LDI = 4'b1111;

  localparam int unsigned FLAG_ZF  = 0;
  localparam int unsigned FLAG_SF  = 1;
  localparam int unsigned FLAG_CF  = 2;
  localparam int unsigned FLAG_COF = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } seq_state_t;

  function automatic logic op_is_alu(input logic [3:0] op);
    return op < 4'(ALU_OPS);
  endfunction

endpackage

// File: rtl/alu_sequencer_regfile.sv
// 4x8 register file: one synchronous write port, three asynchronous read
// ports (two operands plus debug), synchronous active-low reset to zero.
module seq_regfile
  import alu_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       we,
  input  logic [1:0] waddr,
  input  logic [7:0] wdata,
  input  logic [1:0] raddr1,
  input  logic [1:0] raddr2,
  input  logic [1:0] raddr3,
  output logic [7:0] rdata1,
  output logic [7:0] rdata2,
  output logic [7:0] rdata3
);

  logic [7:0] regs [NREG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs <= '{default: '0};
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1 = regs[raddr1];
  assign rdata2 = regs[raddr2];
  assign rdata3 = regs[raddr3];

endmodule

// File: rtl/alu_sequencer.sv
// Instruction sequencer for the 8-bit ALU: accepts an instruction, drives the
// external ALU for one cycle, then writes the result back and latches flags.
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  input  logic [15:0] INSTR,
  output logic [7:0]  ALU_DATA1,
  output logic [7:0]  ALU_DATA2,
  output logic [3:0]  ALU_OPCODE,
  input  logic [7:0]  ALU_DATAOUT,
  input  logic [4:0]  ALU_FLAGS,
  output logic        DONE,
  output logic        ERR,
  output logic [7:0]  RESULT,
  output logic [4:0]  FLAGS,
  input  logic [1:0]  RD_ADDR,
  output logic [7:0]  RD_DATA
);

  seq_state_t state;

  logic [3:0] op_q;
  logic [1:0] rd_q;
  logic [7:0] imm_q;
  logic [7:0] dout_q;
  logic [4:0] flg_q;

  logic [7:0] rs1_data;
  logic [7:0] rs2_data;

  logic       wb_we;
  logic       wb_flags_we;
  logic [7:0] wb_data;
  logic [4:0] wb_flags;

  seq_regfile u_regfile (
    .clk    (CLK),
    .rst_n  (RST_N),
    .we     (wb_we),
    .waddr  (rd_q),
    .wdata  (wb_data),
    .raddr1 (INSTR[9:8]),
    .raddr2 (INSTR[7:6]),
    .raddr3 (RD_ADDR),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data),
    .rdata3 (RD_DATA)
  );

  assign INSTR_READY = (state == S_IDLE);

  // SUB-equal and CMP-equal are cases where the ALU output is not trustworthy,
  // so the known-correct value is substituted here.
  always_comb begin
    wb_we       = 1'b0;
    wb_flags_we = 1'b0;
    wb_data     = dout_q;
    wb_flags    = flg_q;
    if (state == S_WB) begin
      if (op_q == OP_LDI) begin
        wb_we   = 1'b1;
        wb_data = imm_q;
      end else if (op_q == OP_CMP) begin
        wb_flags_we = 1'b1;
        if (flg_q[FLAG_ZF]) begin
          wb_flags[FLAG_COF] = 1'b0;
        end
      end else if (op_is_alu(op_q)) begin
        wb_we       = 1'b1;
        wb_flags_we = 1'b1;
        if (op_q == OP_SUB && ALU_DATA1 == ALU_DATA2) begin
          wb_data  = '0;
          wb_flags = 5'b00001;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      imm_q      <= '0;
      dout_q     <= '0;
      flg_q      <= '0;
      ALU_DATA1  <= '0;
      ALU_DATA2  <= '0;
      ALU_OPCODE <= '0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
      RESULT     <= '0;
      FLAGS      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (INSTR_VALID) begin
            op_q       <= INSTR[15:12];
            rd_q       <= INSTR[11:10];
            imm_q      <= INSTR[7:0];
            ALU_DATA1  <= rs1_data;
            ALU_DATA2  <= rs2_data;
            ALU_OPCODE <= (INSTR[15:12] == OP_LDI) ? OP_ADD : INSTR[15:12];
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          dout_q <= ALU_DATAOUT;
          flg_q  <= ALU_FLAGS;
          DONE   <= 1'b1;
          ERR    <= !op_is_alu(op_q) && (op_q != OP_LDI);
          state  <= S_WB;
        end
        S_WB: begin
          DONE <= 1'b0;
          ERR  <= 1'b0;
          if (wb_we) begin
            RESULT <= wb_data;
          end
          if (wb_flags_we) begin
            FLAGS <= wb_flags;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 8-bit ALU model in
// place of the Processor ALU; undriven ALU outputs are modelled as all-ones.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] instr;
  logic [7:0]  alu_d1;
  logic [7:0]  alu_d2;
  logic [3:0]  alu_op;
  logic [7:0]  alu_out;
  logic [4:0]  alu_flg;
  logic        done;
  logic        err;
  logic [7:0]  result;
  logic [4:0]  flags;
  logic [1:0]  rd_addr;
  logic [7:0]  rd_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .CLK         (clk),
    .RST_N       (rst_n),
    .INSTR_VALID (instr_valid),
    .INSTR_READY (instr_ready),
    .INSTR       (instr),
    .ALU_DATA1   (alu_d1),
    .ALU_DATA2   (alu_d2),
    .ALU_OPCODE  (alu_op),
    .ALU_DATAOUT (alu_out),
    .ALU_FLAGS   (alu_flg),
    .DONE        (done),
    .ERR         (err),
    .RESULT      (result),
    .FLAGS       (flags),
    .RD_ADDR     (rd_addr),
    .RD_DATA     (rd_data)
  );

  // Behavioural ALU; flags {COF,-,CF,SF,ZF}.
  logic [8:0] wide;
  logic [7:0] r;
  always_comb begin
    alu_out = '0;
    alu_flg = '0;
    wide    = '0;
    r       = '0;
    case (alu_op)
      4'h0: begin
        wide = {1'b0, alu_d1} + {1'b0, alu_d2};
        r = wide[7:0];
        alu_flg[2] = wide[8];
        alu_flg[4] = (alu_d1[7] == alu_d2[7]) && (r[7] != alu_d1[7]);
      end
      4'h1, 4'h6: begin
        wide = {1'b0, alu_d1} - {1'b0, alu_d2};
        r = wide[7:0];
        alu_flg[2] = wide[8];
        alu_flg[4] = (alu_d1 == alu_d2) ? 1'b1
                   : ((alu_d1[7] != alu_d2[7]) && (r[7] != alu_d1[7]));
      end
      4'h2: r = alu_d1 & alu_d2;
      4'h3: r = alu_d1 | alu_d2;
      4'h4: r = alu_d1 ^ alu_d2;
      4'h5: r = ~alu_d1;
      4'h7: r = (alu_d2 >= 8'd8) ? 8'h00 : (alu_d1 << alu_d2[2:0]);
      4'h8: r = (alu_d2 >= 8'd8) ? 8'h00 : (alu_d1 >> alu_d2[2:0]);
      default: r = 8'hFF;
    endcase
    alu_flg[0] = (r == 8'h00);
    alu_flg[1] = r[7];
    alu_out = (alu_op == 4'h6) ? 8'hFF : r;
    if (alu_op == 4'h1 && alu_d1 == alu_d2) begin
      alu_out = 8'hFF;
      alu_flg = 5'b11111;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] ldi(input logic [1:0] rd, input logic [7:0] imm);
    return {4'hF, rd, 2'b00, imm};
  endfunction

  function automatic logic [15:0] aop(input logic [3:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2);
    return {op, rd, rs1, rs2, 6'b000000};
  endfunction

  task automatic run(input logic [15:0] ins, input logic exp_err, input string tag);
    int n;
    @(negedge clk);
    instr = ins;
    instr_valid = 1'b1;
    n = 0;
    while (!instr_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready"}, 16'(instr_ready), 16'h1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    chk({tag, " done_exec"}, 16'(done), 16'h0);
    @(posedge clk);
    #1;
    chk({tag, " done_wb"}, 16'(done), 16'h1);
    chk({tag, " err"}, 16'(err), 16'(exp_err));
    @(posedge clk);
    #1;
    chk({tag, " done_idle"}, 16'(done), 16'h0);
  endtask

  task automatic rdchk(input logic [1:0] a, input logic [7:0] exp, input string tag);
    rd_addr = a;
    #1;
    chk(tag, 16'(rd_data), 16'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dcount;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr = '0;
    rd_addr = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst ready", 16'(instr_ready), 16'h1);
    chk("rst done", 16'(done), 16'h0);
    chk("rst err", 16'(err), 16'h0);
    chk("rst result", 16'(result), 16'h0);
    chk("rst flags", 16'(flags), 16'h0);
    chk("rst alu", {alu_d1, alu_d2}, 16'h0);
    chk("rst opcode", 16'(alu_op), 16'h0);
    rdchk(2'd0, 8'h00, "rst r0");
    rdchk(2'd3, 8'h00, "rst r3");

    // 1: LDI / ADD with carry
    run(ldi(2'd0, 8'h0F), 1'b0, "t1 ldi r0");
    chk("t1 ldi result", 16'(result), 16'h0F);
    chk("t1 ldi flags", 16'(flags), 16'h00);
    run(ldi(2'd1, 8'hF5), 1'b0, "t1 ldi r1");
    run(aop(4'h0, 2'd2, 2'd0, 2'd1), 1'b0, "t1 add");
    chk("t1 add result", 16'(result), 16'h04);
    chk("t1 add flags", 16'(flags), 16'b00100);
    rdchk(2'd2, 8'h04, "t1 r2");

    // 2: SUB equal, then CMP equal
    run(ldi(2'd0, 8'h22), 1'b0, "t2 ldi r0");
    run(ldi(2'd1, 8'h22), 1'b0, "t2 ldi r1");
    run(aop(4'h1, 2'd2, 2'd0, 2'd1), 1'b0, "t2 sub");
    chk("t2 sub result", 16'(result), 16'h00);
    chk("t2 sub flags", 16'(flags), 16'b00001);
    rdchk(2'd2, 8'h00, "t2 r2");
    run(ldi(2'd2, 8'h5A), 1'b0, "t2 ldi r2");
    run(aop(4'h0, 2'd3, 2'd0, 2'd1), 1'b0, "t2 add");
    chk("t2 add result", 16'(result), 16'h44);
    chk("t2 add flags", 16'(flags), 16'b00000);
    run(aop(4'h6, 2'd2, 2'd0, 2'd1), 1'b0, "t2 cmp");
    chk("t2 cmp flags", 16'(flags), 16'b00001);
    chk("t2 cmp result", 16'(result), 16'h44);
    rdchk(2'd2, 8'h5A, "t2 r2 kept");

    // 3: shifts, including shift amount >= 8
    run(ldi(2'd0, 8'h81), 1'b0, "t3 ldi r0");
    run(ldi(2'd1, 8'h03), 1'b0, "t3 ldi r1");
    run(aop(4'h7, 2'd3, 2'd0, 2'd1), 1'b0, "t3 shl");
    rdchk(2'd3, 8'h08, "t3 shl r3");
    run(aop(4'h8, 2'd3, 2'd0, 2'd1), 1'b0, "t3 shr");
    rdchk(2'd3, 8'h10, "t3 shr r3");
    chk("t3 shr result", 16'(result), 16'h10);
    run(ldi(2'd1, 8'h09), 1'b0, "t3 ldi r1b");
    run(aop(4'h7, 2'd3, 2'd0, 2'd1), 1'b0, "t3 shl9");
    rdchk(2'd3, 8'h00, "t3 shl9 r3");
    chk("t3 shl9 flags", 16'(flags), 16'b00001);

    // 4: illegal opcode writes nothing
    run(aop(4'hA, 2'd2, 2'd0, 2'd1), 1'b1, "t4 illegal");
    chk("t4 result", 16'(result), 16'h00);
    chk("t4 flags", 16'(flags), 16'b00001);
    rdchk(2'd2, 8'h5A, "t4 r2");
    run(ldi(2'd2, 8'h3C), 1'b0, "t4 ldi");
    chk("t4 ldi result", 16'(result), 16'h3C);

    // 5: VALID held high, one acceptance per READY pulse
    run(ldi(2'd0, 8'h00), 1'b0, "t5 ldi r0");
    run(ldi(2'd1, 8'h01), 1'b0, "t5 ldi r1");
    @(negedge clk);
    instr = aop(4'h0, 2'd0, 2'd0, 2'd1);
    instr_valid = 1'b1;
    dcount = 0;
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("t5 ready c%0d", c), 16'(instr_ready), 16'((c % 3) == 0));
      if (done) dcount++;
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("t5 done count", 16'(dcount), 16'd3);
    rdchk(2'd0, 8'h03, "t5 r0");
    chk("t5 result", 16'(result), 16'h03);

    // 6: reset during EXEC discards the instruction
    run(ldi(2'd0, 8'h10), 1'b0, "t6 ldi r0");
    run(ldi(2'd1, 8'h20), 1'b0, "t6 ldi r1");
    @(negedge clk);
    instr = aop(4'h0, 2'd2, 2'd0, 2'd1);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("t6 done in rst", 16'(done), 16'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("t6 ready after rst", 16'(instr_ready), 16'h1);
    dcount = 0;
    for (int c = 0; c < 3; c++) begin
      if (done) dcount++;
      @(posedge clk);
      #1;
    end
    chk("t6 no done", 16'(dcount), 16'd0);
    rdchk(2'd2, 8'h00, "t6 r2");
    chk("t6 result", 16'(result), 16'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
